multiword_add_seq: RTL and testbench



---
 rtl/multiword_add_seq.sv | 125 ++++++++++++
 tb/tb_multiword_add_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// Multi-cycle wide adder: adds two N*WORDS-bit operands one N-bit chunk per cycle.
// Optional subtract mode is enabled by defining MULTIWORD_ADD_SEQ_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               busy,
  output logic [1:0]         fsm_state
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_reg, b_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_chunk, b_chunk, s_chunk;
  logic [N:0]       c;
  logic             last;
  logic [W-1:0]     b_load;
  logic             carry_load;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is only high in IDLE, out_valid only in DONE.
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign fsm_state = state;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  // a - b is a + ~b + 1; cout then reads as "no borrow".
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign a_chunk = a_reg[idx*N +: N];
  assign b_chunk = b_reg[idx*N +: N];
  assign c[0]    = carry_reg;
  assign last    = (idx == IDX_W'(WORDS - 1));

  for (genvar i = 0; i < N; i++) begin : g_slice
    full_adder u_fa (
      .a  (a_chunk[i]),
      .b  (b_chunk[i]),
      .ci (c[i]),
      .s  (s_chunk[i]),
      .co (c[i+1])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            idx       <= '0;
          end
        end
        RUN: begin
          // sum_reg is overwritten chunk by chunk, never cleared up front.
          sum_reg[idx*N +: N] <= s_chunk;
          carry_reg           <= c[N];
          if (last) cout_reg <= c[N];
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (N=4, WORDS=4) plus a WORDS=1 instance.
// Subtract vectors run only when MULTIWORD_ADD_SEQ_SUB_EN is defined.

module tb_multiword_add_seq;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
  logic [1:0]   fsm_state;

  logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, busy1;
  logic [N-1:0] a1, b1, sum1;
  logic [1:0]   fsm_state1;

  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy), .fsm_state(fsm_state)
  );

  multiword_add_seq #(.N(N), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
    .busy(busy1), .fsm_state(fsm_state1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops one expected {cout,sum} per result handed to the consumer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %0h expected none", {cout, sum});
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
          n_err++;
          $display("FAIL result: got %0h expected %0h", {cout, sum}, e);
        end
      end
    end
  end

  // Presents operands and returns #1 after the acceptance edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tcin, input logic tsub);
    bit ok;
    ok = 0;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_err++;
      $display("FAIL wait_valid_timeout: got out_valid=0 expected 1");
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;

    // Reset values, including in_ready held low while rst is high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // WORDS=1: F + 1 + 1 = 0x11, latency one cycle.
    @(posedge clk); #1;
    in_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1;
    @(negedge clk);
    chk("w1_in_ready", in_ready1, 1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_valid_early", out_valid1, 0);
    @(negedge clk);
    chk("w1_valid", out_valid1, 1);
    chk("w1_sum", sum1, 4'h1);
    chk("w1_cout", cout1, 1);
    @(posedge clk); #1 out_ready1 = 1'b1;
    @(posedge clk); #1 out_ready1 = 1'b0;
    @(negedge clk);
    chk("w1_valid_after_take", out_valid1, 0);

    // FFFF + 0001: exact 4-cycle latency, in_ready low throughout.
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'h0000});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_out_valid_low", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
    end
    @(negedge clk);
    chk("lat_out_valid_high", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;

    // Carry into chunk 0 from cin.
    exp_q.push_back({1'b0, 16'h5556});
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 16'hBE01});
    send(16'hABCD, 16'h1234, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 16'hFFFF});
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_valid();
    @(posedge clk); #1;

    // Backpressure with changing operands offered.
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h1000});
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0303 * 16'(i + 1); cin = i[0];
      @(negedge clk);
      chk("bp_sum", sum, 16'h1000);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000; cin = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 16'h0001});
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted_busy", busy, 1);
    wait_valid();
    @(posedge clk); #1;

    // Reset after chunk 2 aborts the operation.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    exp_q.push_back({1'b0, 16'hFFFE});
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 16'h0002});
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_valid();
    @(posedge clk); #1;
`endif

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
